// File: rtl/ram_to_fifo_pkg.sv
// ram_to_fifo_pkg
// Shared constants and helpers for the ram_to_fifo_multitap coefficient RAM.
//   WRAP_MOD / WRAP_CLAMP / WRAP_ZERO : encodings of the WRAP_MODE parameter
//   MAX_TAPS                          : largest supported NTAPS
//   tap_lane(k, dwidth)               : bit offset of tap k inside o_tdata
package ram_to_fifo_pkg;

  localparam int WRAP_MOD   = 0;
  localparam int WRAP_CLAMP = 1;
  localparam int WRAP_ZERO  = 2;

  localparam int MAX_TAPS = 8;

  function automatic int tap_lane(input int k, input int dwidth);
    return k * dwidth;
  endfunction

endpackage

// File: rtl/ram_2port.sv
// ram_2port
// Simple dual-port RAM: one write port, one registered read port with enable.
// A read and a write to the same address in the same cycle return the old word
// (read-first). Contents are not reset; only the read register is.
//   clk, reset_n     : clock, async active-low reset of the read register
//   we, waddr, wdata : write port
//   re, raddr        : read enable / address; rdata updates only when re=1
//   rdata            : registered read data
module ram_2port #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];
  logic [DWIDTH-1:0] rdata_q;
  logic [DWIDTH-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_to_fifo_tap_addr.sv
// ram_to_fifo_tap_addr
// Computes the RAM address for one tap (base + TAP) against the programmed
// table length, plus its out-of-range flag.
//   base : base read address a
//   len  : current table length L (1 .. 2^AWIDTH)
//   addr : RAM address for this tap after end-of-table handling
//   oor  : raw address r = a+TAP is past the table (or a itself is)
module ram_to_fifo_tap_addr
  import ram_to_fifo_pkg::*;
#(
  parameter int AWIDTH    = 10,
  parameter int WRAP_MODE = WRAP_MOD,
  parameter int TAP       = 0
) (
  input  logic [AWIDTH-1:0] base,
  input  logic [AWIDTH:0]   len,
  output logic [AWIDTH-1:0] addr,
  output logic              oor
);

  localparam logic [AWIDTH:0] K = (AWIDTH+1)'(TAP);

  logic [AWIDTH:0] raw;
  logic            base_oor;
  logic            raw_oor;

  always_comb begin
    raw      = {1'b0, base} + K;
    base_oor = ({1'b0, base} >= len);
    raw_oor  = (raw >= len);
    oor      = base_oor | raw_oor;
    addr     = raw[AWIDTH-1:0];
    if (WRAP_MODE == WRAP_MOD) begin
      // A base already past the table falls back to plain modulo-2^AWIDTH.
      if (!base_oor && raw_oor) addr = AWIDTH'(raw - len);
    end else if (WRAP_MODE == WRAP_CLAMP) begin
      if (oor) addr = AWIDTH'(len - (AWIDTH+1)'(1));
    end
    // WRAP_ZERO keeps the raw address; the data lane is zeroed downstream.
  end

endmodule

// File: rtl/ram_to_fifo_multitap.sv
// ram_to_fifo_multitap
// Coefficient RAM loaded in order over a config stream and read over an
// address stream. Each accepted base address returns NTAPS consecutive words
// on one wide output beat, one cycle later. One RAM copy per tap so all taps
// are read in parallel.
//   clk, reset_n, clear       : clock, async active-low reset, sync clear
//   config_t*                 : coefficient load stream (always ready)
//   i_t*                      : base address stream
//   o_t*                      : tap data stream, tap k at bits [k*DWIDTH +: DWIDTH]
//   table_len                 : current programmed length (2^AWIDTH after reset)
// Optional build macro RAM_TO_FIFO_RANGE_ERR_EN adds o_tuser (per-tap
// out-of-range flags) and range_err (sticky: base address past the table).
// NTAPS must be in 1..MAX_TAPS.
module ram_to_fifo_multitap
  import ram_to_fifo_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 10,
  parameter int NTAPS     = 2,
  parameter int WRAP_MODE = WRAP_MOD
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [DWIDTH-1:0]       config_tdata,
  input  logic                    config_tlast,
  input  logic                    config_tvalid,
  output logic                    config_tready,
  input  logic [AWIDTH-1:0]       i_tdata,
  input  logic                    i_tlast,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [NTAPS*DWIDTH-1:0] o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready,
`ifdef RAM_TO_FIFO_RANGE_ERR_EN
  output logic [NTAPS-1:0]        o_tuser,
  output logic                    range_err,
`endif
  output logic [AWIDTH:0]         table_len
);

  localparam logic [AWIDTH:0] FULL_LEN = {1'b1, {AWIDTH{1'b0}}};

  logic [AWIDTH-1:0] write_addr_q, write_addr_d;
  logic [AWIDTH:0]   table_len_q, table_len_d;
  logic              o_tvalid_q, o_tvalid_d;
  logic              o_tlast_q, o_tlast_d;
  logic [NTAPS-1:0]  oor_q, oor_d;
  logic [NTAPS-1:0]  tap_oor;
  logic [NTAPS*DWIDTH-1:0] ram_rdata;
  logic              accept;

  assign config_tready = 1'b1;
  assign i_tready      = ~o_tvalid_q | o_tready;
  assign accept        = i_tvalid & i_tready;

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    logic [AWIDTH-1:0] tap_addr;

    ram_to_fifo_tap_addr #(
      .AWIDTH    (AWIDTH),
      .WRAP_MODE (WRAP_MODE),
      .TAP       (k)
    ) u_addr (
      .base (i_tdata),
      .len  (table_len_q),
      .addr (tap_addr),
      .oor  (tap_oor[k])
    );

    // Every copy receives every config beat; copy k is only read for tap k.
    ram_2port #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH)
    ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (config_tvalid),
      .waddr   (write_addr_q),
      .wdata   (config_tdata),
      .re      (accept),
      .raddr   (tap_addr),
      .rdata   (ram_rdata[tap_lane(k, DWIDTH) +: DWIDTH])
    );

    assign o_tdata[tap_lane(k, DWIDTH) +: DWIDTH] =
      (WRAP_MODE == WRAP_ZERO && oor_q[k]) ? '0
                                           : ram_rdata[tap_lane(k, DWIDTH) +: DWIDTH];
  end

`ifdef RAM_TO_FIFO_RANGE_ERR_EN
  logic range_err_q, range_err_d;
  logic base_oor;

  assign base_oor = ({1'b0, i_tdata} >= table_len_q);

  always_comb begin
    range_err_d = range_err_q;
    if (accept && base_oor) range_err_d = 1'b1;
    if (clear)              range_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) range_err_q <= 1'b0;
    else          range_err_q <= range_err_d;
  end

  assign o_tuser   = oor_q;
  assign range_err = range_err_q;
`endif

  always_comb begin
    write_addr_d = write_addr_q;
    table_len_d  = table_len_q;
    o_tvalid_d   = accept | (o_tvalid_q & ~o_tready);
    o_tlast_d    = o_tlast_q;
    oor_d        = oor_q;

    if (config_tvalid) begin
      write_addr_d = write_addr_q + 1'b1;
      if (config_tlast) begin
        table_len_d  = {1'b0, write_addr_q} + 1'b1;
        write_addr_d = '0;
      end
    end

    // Sideband is captured alongside the RAM read so it stays aligned while stalled.
    if (accept) begin
      o_tlast_d = i_tlast;
      oor_d     = tap_oor;
    end

    if (clear) begin
      write_addr_d = '0;
      table_len_d  = FULL_LEN;
      o_tvalid_d   = 1'b0;
      o_tlast_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_addr_q <= '0;
      table_len_q  <= FULL_LEN;
      o_tvalid_q   <= 1'b0;
      o_tlast_q    <= 1'b0;
      oor_q        <= '0;
    end else begin
      write_addr_q <= write_addr_d;
      table_len_q  <= table_len_d;
      o_tvalid_q   <= o_tvalid_d;
      o_tlast_q    <= o_tlast_d;
      oor_q        <= oor_d;
    end
  end

  assign o_tvalid  = o_tvalid_q;
  assign o_tlast   = o_tlast_q;
  assign table_len = table_len_q;

endmodule

// File: tb/tb_ram_to_fifo_multitap.sv
// Bench for ram_to_fifo_multitap: three instances (WRAP_MODE 0, 1, 2) with
// NTAPS=4 share one stimulus. Expected beats are queued when an address is
// accepted and compared when the output beat is taken.
module tb_ram_to_fifo_multitap;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NT = 4;
  localparam int OW = NT * DW;

  typedef struct {
    logic [2:0][OW-1:0] exp;
    logic               last;
    bit                 chk;
  } sb_t;

  typedef struct {
    int                 a;
    bit                 last;
    logic [2:0][OW-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n, clear;
  logic [DW-1:0] config_tdata;
  logic config_tlast, config_tvalid;
  logic [AW-1:0] i_tdata;
  logic i_tlast, i_tvalid, o_tready;

  logic [2:0]    cfg_rdy, i_tready, o_tlast, o_tvalid;
  logic [OW-1:0] o_tdata   [3];
  logic [AW:0]   table_len [3];
`ifdef RAM_TO_FIFO_RANGE_ERR_EN
  logic [NT-1:0] o_tuser [3];
  logic [2:0]    range_err;
`endif

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    ram_to_fifo_multitap #(
      .DWIDTH(DW), .AWIDTH(AW), .NTAPS(NT), .WRAP_MODE(m)
    ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .clear         (clear),
      .config_tdata  (config_tdata),
      .config_tlast  (config_tlast),
      .config_tvalid (config_tvalid),
      .config_tready (cfg_rdy[m]),
      .i_tdata       (i_tdata),
      .i_tlast       (i_tlast),
      .i_tvalid      (i_tvalid),
      .i_tready      (i_tready[m]),
      .o_tdata       (o_tdata[m]),
      .o_tlast       (o_tlast[m]),
      .o_tvalid      (o_tvalid[m]),
      .o_tready      (o_tready),
`ifdef RAM_TO_FIFO_RANGE_ERR_EN
      .o_tuser       (o_tuser[m]),
      .range_err     (range_err[m]),
`endif
      .table_len     (table_len[m])
    );
  end

  int checks = 0;
  int errors = 0;
  sb_t sbq[$];
  logic [DW-1:0] mdl_mem [1024];
  int mdl_len = 1024;
  int mdl_waddr = 0;
  bit next_exp_valid = 0;
  bit next_chk = 1;
  logic [2:0][OW-1:0] next_exp;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] pack4(input int t0, input int t1, input int t2, input int t3);
    logic [OW-1:0] v;
    v = {t3[DW-1:0], t2[DW-1:0], t1[DW-1:0], t0[DW-1:0]};
    return v;
  endfunction

  // Reference taps straight from the end-of-table rules.
  function automatic logic [OW-1:0] mdl_taps(input int mode, input int a);
    logic [OW-1:0] res;
    res = '0;
    for (int k = 0; k < NT; k++) begin
      int r;
      int idx;
      bit oor;
      r   = a + k;
      oor = (a >= mdl_len) || (r >= mdl_len);
      if (mode == 0)      idx = (a >= mdl_len) ? r % 1024 : ((r >= mdl_len) ? r - mdl_len : r);
      else if (mode == 1) idx = oor ? mdl_len - 1 : r;
      else                idx = r % 1024;
      res[k*DW +: DW] = (mode == 2 && oor) ? '0 : mdl_mem[idx];
    end
    return res;
  endfunction

  // One clock: settle inputs, score both handshakes, update model, advance.
  task automatic cycle();
    sb_t e;
    #1;
    chk("i_tready", i_tready[0], (!o_tvalid[0]) || o_tready);
    if (o_tvalid[0] && o_tready) begin
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got o_tvalid=1 expected no beat");
      end else begin
        e = sbq.pop_front();
        for (int m = 0; m < 3; m++) begin
          if (e.chk) chk($sformatf("tdata_mode%0d", m), o_tdata[m], e.exp[m]);
          chk($sformatf("tlast_mode%0d", m), o_tlast[m], e.last);
          chk($sformatf("tvalid_mode%0d", m), o_tvalid[m], 1'b1);
        end
      end
    end
    if (i_tvalid && i_tready[0]) begin
      for (int m = 0; m < 3; m++)
        e.exp[m] = next_exp_valid ? next_exp[m] : mdl_taps(m, int'(i_tdata));
      e.last = i_tlast;
      e.chk  = next_chk;
      sbq.push_back(e);
    end
    if (config_tvalid) begin
      mdl_mem[mdl_waddr] = config_tdata;
      if (config_tlast) begin
        mdl_len   = mdl_waddr + 1;
        mdl_waddr = 0;
      end else begin
        mdl_waddr = (mdl_waddr + 1) % 1024;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) cycle();
    chk("drain_empty", sbq.size(), 0);
    cycle();
  endtask

  task automatic load16();
    for (int i = 0; i < 16; i++) begin
      config_tvalid = 1'b1;
      config_tdata  = 100 + i;
      config_tlast  = (i == 15);
      cycle();
    end
    config_tvalid = 1'b0;
    config_tlast  = 1'b0;
  endtask

  task automatic read1(input int a, input bit last);
    i_tvalid = 1'b1;
    i_tdata  = a[AW-1:0];
    i_tlast  = last;
    cycle();
    i_tvalid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{a:14, last:0, exp:{pack4(114,115,0,0),   pack4(114,115,115,115), pack4(114,115,100,101)}};
    vecs[1] = '{a:0,  last:1, exp:{pack4(100,101,102,103), pack4(100,101,102,103), pack4(100,101,102,103)}};
    vecs[2] = '{a:13, last:0, exp:{pack4(113,114,115,0), pack4(113,114,115,115), pack4(113,114,115,100)}};
    vecs[3] = '{a:15, last:1, exp:{pack4(115,0,0,0),     pack4(115,115,115,115), pack4(115,100,101,102)}};
    vecs[4] = '{a:12, last:0, exp:{pack4(112,113,114,115), pack4(112,113,114,115), pack4(112,113,114,115)}};

    reset_n = 1'b0; clear = 1'b0;
    config_tdata = '0; config_tlast = 1'b0; config_tvalid = 1'b0;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    for (int m = 0; m < 3; m++) begin
      chk("rst_tvalid", o_tvalid[m], 1'b0);
      chk("rst_tlast", o_tlast[m], 1'b0);
      chk("rst_tdata", o_tdata[m], '0);
      chk("rst_table_len", table_len[m], 11'd1024);
      chk("cfg_tready", cfg_rdy[m], 1'b1);
    end

    load16();
    for (int m = 0; m < 3; m++) chk("table_len_16", table_len[m], 11'd16);

    // Table vectors, issued back to back.
    next_exp_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_tvalid = 1'b1;
      i_tdata  = vecs[i].a[AW-1:0];
      i_tlast  = vecs[i].last;
      next_exp = vecs[i].exp;
      cycle();
    end
    next_exp_valid = 1'b0;
    drain();

    // Streaming a=0..7, one beat per cycle.
    for (int a = 0; a < 8; a++) begin
      i_tvalid = 1'b1;
      i_tdata  = a[AW-1:0];
      i_tlast  = (a == 7);
      cycle();
      if (a > 0) chk("stream_tvalid", o_tvalid[0], 1'b1);
    end
    drain();

    // Output stall for 5 cycles.
    read1(8, 0);
    o_tready = 1'b0;
    i_tvalid = 1'b1; i_tdata = 9; i_tlast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      for (int m = 0; m < 3; m++) begin
        chk("stall_tvalid", o_tvalid[m], 1'b1);
        chk("stall_tdata", o_tdata[m], sbq[0].exp[m]);
      end
    end
    o_tready = 1'b1;
    cycle();
    drain();

    // Write/read collision at address 3: old word first, new word next.
    for (int i = 0; i < 3; i++) begin
      config_tvalid = 1'b1; config_tdata = 100 + i; config_tlast = 1'b0;
      cycle();
    end
    config_tdata = 32'h0000AAAA;
    i_tvalid = 1'b1; i_tdata = 3; i_tlast = 1'b0;
    next_exp_valid = 1'b1;
    next_exp = {pack4(103,104,105,106), pack4(103,104,105,106), pack4(103,104,105,106)};
    cycle();
    next_exp_valid = 1'b0;
    config_tvalid = 1'b0;
    i_tdata = 3;
    next_exp_valid = 1'b1;
    next_exp = {pack4('hAAAA,104,105,106), pack4('hAAAA,104,105,106), pack4('hAAAA,104,105,106)};
    cycle();
    next_exp_valid = 1'b0;
    drain();

    // Clear while an output beat is stalled: beat is dropped.
    o_tready = 1'b0;
    read1(5, 1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    for (int m = 0; m < 3; m++) begin
      chk("clear_tvalid", o_tvalid[m], 1'b0);
      chk("clear_table_len", table_len[m], 11'd1024);
    end
    void'(sbq.pop_back());
    mdl_len = 1024; mdl_waddr = 0;
    o_tready = 1'b1;
    read1(0, 0);
    drain();

    // Base address past the table.
    load16();
    next_chk = 1'b0;
    read1(20, 1);
    next_chk = 1'b1;
`ifdef RAM_TO_FIFO_RANGE_ERR_EN
    for (int m = 0; m < 3; m++) begin
      chk("tuser_oor", o_tuser[m], 4'b1111);
      chk("range_err_set", range_err[m], 1'b1);
    end
`endif
    drain();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    mdl_len = 1024; mdl_waddr = 0;
`ifdef RAM_TO_FIFO_RANGE_ERR_EN
    for (int m = 0; m < 3; m++) chk("range_err_clr", range_err[m], 1'b0);
`endif

    // Async reset in the middle of a stall.
    o_tready = 1'b0;
    read1(1, 1);
    #3;
    reset_n = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) begin
      chk("async_rst_tvalid", o_tvalid[m], 1'b0);
      chk("async_rst_table_len", table_len[m], 11'd1024);
    end
    sbq.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mdl_len = 1024; mdl_waddr = 0;
    o_tready = 1'b1;
    read1(0, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
